// File: rtl/apb_regbank_slv_pkg.sv
// Shared types and constants for the APB register bank: bus records, PnP
// descriptor, FSM state codes and the register-file record with its reset value.
package apb_regbank_slv_pkg;

    localparam logic [15:0] VENDOR_OPTIMITY          = 16'h00F1;
    localparam logic [15:0] OPTIMITY_DID_APB_REGBANK = 16'h0088;
    localparam logic [1:0]  PNP_CFG_TYPE_SLAVE       = 2'b10;
    localparam logic [7:0]  PNP_CFG_DEV_DESCR_BYTES  = 8'h10;

    localparam logic [1:0] State_Idle = 2'd0;
    localparam logic [1:0] State_Wait = 2'd1;
    localparam logic [1:0] State_Resp = 2'd2;

    localparam int          REG_COUNT   = 8;
    localparam logic [2:0]  REG_ID      = 3'd0;
    localparam logic [2:0]  REG_SCRATCH = 3'd1;

    typedef struct packed {
        logic [31:0] addr_start;
        logic [31:0] addr_end;
    } mapinfo_type;

    typedef struct packed {
        logic [7:0]  descrsize;
        logic [1:0]  desctype;
        logic [31:0] addr_start;
        logic [31:0] addr_end;
        logic [15:0] vid;
        logic [15:0] did;
    } dev_config_type;

    typedef struct packed {
        logic        pselx;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
    } apb_in_type;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_out_type;

    typedef struct packed {
        logic [1:0]       state;
        logic [3:0]       wcnt;
        logic [9:0]       req_addr;   // paddr[11:2] of the accepted request
        logic             req_write;
        logic [31:0]      req_wdata;
        logic [3:0]       req_strb;
        logic [7:1][31:0] regs;
        logic [31:0]      prdata;
        logic             pslverr;
        logic [31:0]      scratch;
    } apb_regbank_slv_registers;

    localparam apb_regbank_slv_registers apb_regbank_slv_r_reset = '{
        state:     State_Idle,
        wcnt:      4'd0,
        req_addr:  10'd0,
        req_write: 1'b0,
        req_wdata: 32'd0,
        req_strb:  4'd0,
        regs:      '0,
        prdata:    32'd0,
        pslverr:   1'b0,
        scratch:   32'd0
    };

    // Out-of-window offsets and writes to the read-only ID word are rejected.
    function automatic logic access_error(input logic [9:0] word_addr, input logic write);
        return (word_addr[9:3] != 7'd0) || (write && (word_addr[2:0] == REG_ID));
    endfunction

endpackage

// File: rtl/apb_regbank_slv.sv
// APB completer with one read-only ID word and seven byte-strobed R/W words,
// a programmable number of wait states and requester-abort handling.
module apb_regbank_slv
    import apb_regbank_slv_pkg::*;
#(
    parameter int unsigned waitstates = 0,
    parameter logic [15:0] vid        = VENDOR_OPTIMITY,
    parameter logic [15:0] did        = OPTIMITY_DID_APB_REGBANK
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    input  mapinfo_type    i_mapinfo,
    output dev_config_type o_cfg,
    input  apb_in_type     i_apbi,
    output apb_out_type    o_apbo,
    output logic [31:0]    o_scratch
);

    apb_regbank_slv_registers r_q;
    apb_regbank_slv_registers r_d;

    logic [31:0] word      [REG_COUNT];
    logic [31:0] wmask;
    logic [2:0]  idx;
    logic        err;
    logic [31:0] merged;
    logic        unused_apb;

    assign unused_apb = ^{i_apbi.pprot, i_apbi.paddr[31:12], i_apbi.paddr[1:0]};

    assign word[0] = {vid, did};
    for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_word
        assign word[gi] = r_q.regs[gi];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
        assign wmask[gi*8 +: 8] = {8{r_q.req_strb[gi]}};
    end

    assign idx    = r_q.req_addr[2:0];
    assign err    = access_error(r_q.req_addr, r_q.req_write);
    assign merged = (word[idx] & ~wmask) | (r_q.req_wdata & wmask);

    always_comb begin
        r_d         = r_q;
        r_d.scratch = r_q.regs[REG_SCRATCH];
        case (r_q.state)
            State_Idle: begin
                if (i_apbi.pselx && !i_apbi.penable) begin
                    r_d.state     = State_Wait;
                    r_d.req_addr  = i_apbi.paddr[11:2];
                    r_d.req_write = i_apbi.pwrite;
                    r_d.req_wdata = i_apbi.pwdata;
                    r_d.req_strb  = i_apbi.pstrb;
                    r_d.wcnt      = 4'(waitstates);
                end
            end
            State_Wait: begin
                if (!i_apbi.pselx) begin
                    r_d.state = State_Idle;
                end else if (r_q.wcnt != 4'd0) begin
                    r_d.wcnt = r_q.wcnt - 4'd1;
                end else begin
                    r_d.state   = State_Resp;
                    r_d.prdata  = 32'd0;
                    r_d.pslverr = err;
                    if (!err) begin
                        if (r_q.req_write) begin
                            r_d.regs[idx] = merged;
                        end else begin
                            r_d.prdata = word[idx];
                        end
                    end
                end
            end
            State_Resp: begin
                r_d.state   = State_Idle;
                r_d.prdata  = 32'd0;
                r_d.pslverr = 1'b0;
            end
            default: begin
                r_d.state = State_Idle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_q <= apb_regbank_slv_r_reset;
        end else begin
            r_q <= r_d;
        end
    end

    // Response fields are forced low whenever the FSM is not presenting a result.
    always_comb begin
        o_apbo.pready  = (r_q.state == State_Resp);
        o_apbo.prdata  = o_apbo.pready ? r_q.prdata : 32'd0;
        o_apbo.pslverr = o_apbo.pready ? r_q.pslverr : 1'b0;
    end

    assign o_scratch = r_q.scratch;

    always_comb begin
        o_cfg.descrsize  = PNP_CFG_DEV_DESCR_BYTES;
        o_cfg.desctype   = PNP_CFG_TYPE_SLAVE;
        o_cfg.addr_start = i_mapinfo.addr_start;
        o_cfg.addr_end   = i_mapinfo.addr_end;
        o_cfg.vid        = vid;
        o_cfg.did        = did;
    end

endmodule

// File: tb/tb_apb_regbank_slv.sv
// Directed bench for apb_regbank_slv: four instances with 0/3/5/2 wait states
// exercised by per-feature tasks with hand-computed expectations.
module tb_apb_regbank_slv;
    import apb_regbank_slv_pkg::*;

    localparam int NCYC = 12;

    logic           clk;
    logic           nrst    [4];
    mapinfo_type    mapinfo;
    dev_config_type cfg     [4];
    apb_in_type     apbi    [4];
    apb_out_type    apbo    [4];
    logic [31:0]    scratch [4];

    int total = 0;
    int bad   = 0;

    // Instance index: 0 -> 0 wait states, 1 -> 3, 2 -> 5, 3 -> 2.
    apb_regbank_slv #(.waitstates(0)) u_ws0 (
        .i_clk(clk), .i_nrst(nrst[0]), .i_mapinfo(mapinfo), .o_cfg(cfg[0]),
        .i_apbi(apbi[0]), .o_apbo(apbo[0]), .o_scratch(scratch[0]));
    apb_regbank_slv #(.waitstates(3)) u_ws3 (
        .i_clk(clk), .i_nrst(nrst[1]), .i_mapinfo(mapinfo), .o_cfg(cfg[1]),
        .i_apbi(apbi[1]), .o_apbo(apbo[1]), .o_scratch(scratch[1]));
    apb_regbank_slv #(.waitstates(5)) u_ws5 (
        .i_clk(clk), .i_nrst(nrst[2]), .i_mapinfo(mapinfo), .o_cfg(cfg[2]),
        .i_apbi(apbi[2]), .o_apbo(apbo[2]), .o_scratch(scratch[2]));
    apb_regbank_slv #(.waitstates(2)) u_ws2 (
        .i_clk(clk), .i_nrst(nrst[3]), .i_mapinfo(mapinfo), .o_cfg(cfg[3]),
        .i_apbi(apbi[3]), .o_apbo(apbo[3]), .o_scratch(scratch[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one transfer over NCYC cycles; cycle 0 is the setup cycle.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int abort_cyc, input int rst_cyc,
                        output int rdy_cyc, output int rdy_cnt,
                        output logic [31:0] rdata, output logic err,
                        output logic [31:0] scr_after, output logic rst_dirty);
        rdy_cyc   = -1;
        rdy_cnt   = 0;
        rdata     = '0;
        err       = 1'b0;
        scr_after = '0;
        rst_dirty = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                apbi[k].pselx   = 1'b1;
                apbi[k].penable = 1'b0;
                apbi[k].pwrite  = wr;
                apbi[k].paddr   = addr;
                apbi[k].pwdata  = wdata;
                apbi[k].pstrb   = strb;
                apbi[k].pprot   = 3'b101;
            end else if (rdy_cyc >= 0 || (abort_cyc >= 0 && c >= abort_cyc)
                         || (rst_cyc >= 0 && c >= rst_cyc)) begin
                apbi[k].pselx   = 1'b0;
                apbi[k].penable = 1'b0;
            end else begin
                apbi[k].penable = 1'b1;
            end
            if (c == rst_cyc) nrst[k] = 1'b0;
            if (rst_cyc >= 0 && c == rst_cyc + 2) nrst[k] = 1'b1;
            @(negedge clk);
            if (rst_cyc >= 0 && c >= rst_cyc && c < rst_cyc + 2
                && (apbo[k] !== '0 || scratch[k] !== 32'd0)) rst_dirty = 1'b1;
            if (apbo[k].pready === 1'b1) begin
                if (rdy_cyc < 0) begin
                    rdy_cyc = c;
                    rdata   = apbo[k].prdata;
                    err     = apbo[k].pslverr;
                end
                rdy_cnt++;
            end
            if (rdy_cyc >= 0 && c == rdy_cyc + 1) scr_after = scratch[k];
        end
        apbi[k] = '0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            nrst[k] = 1'b0;
            apbi[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({apbo[k], scratch[k]} !== '0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got apbo=%h scratch=%h want 0", k, apbo[k], scratch[k]);
            end
        end
        total++;
        if (cfg[0].vid !== 16'h00F1 || cfg[0].did !== 16'h0088) begin
            bad++;
            $display("FAIL cfg_ids: got vid=%h did=%h want 00f1 0088", cfg[0].vid, cfg[0].did);
        end
        total++;
        if (cfg[1].desctype !== 2'b10 || cfg[1].descrsize !== 8'h10) begin
            bad++;
            $display("FAIL cfg_type: got type=%b size=%h want 10 10", cfg[1].desctype, cfg[1].descrsize);
        end
        total++;
        if (cfg[2].addr_start !== 32'h8000_1000 || cfg[2].addr_end !== 32'h8000_2000) begin
            bad++;
            $display("FAIL cfg_addr: got %h..%h want 80001000..80002000", cfg[2].addr_start, cfg[2].addr_end);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) nrst[k] = 1'b1;
        $display("reset: done");
    endtask

    task automatic test_write_full();
        int rc, rn;
        logic [31:0] rd, sc;
        logic er, dirty;
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("write 0x04=deadbeef ws0: ready_cyc=%0d n=%0d err=%b scratch=%h", rc, rn, er, sc);
        total++;
        if (rc !== 2 || rn !== 1) begin
            bad++;
            $display("FAIL wr_latency: got cyc=%0d n=%0d want cyc=2 n=1", rc, rn);
        end
        total++;
        if (er !== 1'b0) begin
            bad++;
            $display("FAIL wr_err: got %b want 0", er);
        end
        total++;
        if (sc !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL scratch: got %h want deadbeef", sc);
        end
    endtask

    task automatic test_strobe();
        int rc, rn;
        logic [31:0] rd, sc;
        logic er, dirty;
        xfer(0, 1'b1, 32'h04, 32'h00000055, 4'h1, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("write 0x04=00000055 strb=1: err=%b", er);
        total++;
        if (er !== 1'b0) begin
            bad++;
            $display("FAIL strb_wr_err: got %b want 0", er);
        end
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("read 0x04: data=%h err=%b", rd, er);
        total++;
        if (rd !== 32'hDEADBE55 || er !== 1'b0) begin
            bad++;
            $display("FAIL strb_rd: got %h/%b want deadbe55/0", rd, er);
        end
        xfer(0, 1'b0, 32'h07, 32'h0, 4'h0, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("read 0x07: data=%h err=%b", rd, er);
        total++;
        if (rd !== 32'hDEADBE55 || er !== 1'b0) begin
            bad++;
            $display("FAIL low_addr_bits: got %h/%b want deadbe55/0", rd, er);
        end
    endtask

    task automatic test_id();
        int rc, rn;
        logic [31:0] rd, sc;
        logic er, dirty;
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("read ID ws3: ready_cyc=%0d n=%0d data=%h err=%b", rc, rn, rd, er);
        total++;
        if (rc !== 5 || rn !== 1) begin
            bad++;
            $display("FAIL id_latency: got cyc=%0d n=%0d want cyc=5 n=1", rc, rn);
        end
        total++;
        if (rd !== 32'h00F1_0088 || er !== 1'b0) begin
            bad++;
            $display("FAIL id_value: got %h/%b want 00f10088/0", rd, er);
        end
        xfer(1, 1'b1, 32'h00, 32'h12345678, 4'hF, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("write ID ws3: data=%h err=%b", rd, er);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL id_write_err: got %h/%b want 0/1", rd, er);
        end
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("reread ID ws3: data=%h", rd);
        total++;
        if (rd !== 32'h00F1_0088) begin
            bad++;
            $display("FAIL id_unchanged: got %h want 00f10088", rd);
        end
    endtask

    task automatic test_bad_addr();
        int rc, rn;
        logic [31:0] rd, sc;
        logic er, dirty;
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("read 0x40: data=%h err=%b", rd, er);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL bad_rd: got %h/%b want 0/1", rd, er);
        end
        xfer(0, 1'b1, 32'h44, 32'hFFFFFFFF, 4'hF, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("write 0x44: err=%b", er);
        total++;
        if (er !== 1'b1) begin
            bad++;
            $display("FAIL bad_wr: got %b want 1", er);
        end
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("read 0x04 after bad write: data=%h", rd);
        total++;
        if (rd !== 32'hDEADBE55) begin
            bad++;
            $display("FAIL bad_no_change: got %h want deadbe55", rd);
        end
    endtask

    task automatic test_abort();
        int rc, rn;
        logic [31:0] rd, sc;
        logic er, dirty;
        xfer(2, 1'b1, 32'h08, 32'h12345678, 4'hF, 2, -1, rc, rn, rd, er, sc, dirty);
        $display("aborted write 0x08 ws5: ready_n=%0d", rn);
        total++;
        if (rn !== 0) begin
            bad++;
            $display("FAIL abort_ready: got %0d pulses want 0", rn);
        end
        xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("read 0x08 ws5: ready_cyc=%0d data=%h", rc, rd);
        total++;
        if (rc !== 7 || rd !== 32'h0) begin
            bad++;
            $display("FAIL abort_rd: got cyc=%0d data=%h want 7/0", rc, rd);
        end
    endtask

    task automatic test_reset_mid();
        int rc, rn;
        logic [31:0] rd, sc;
        logic er, dirty;
        xfer(3, 1'b1, 32'h10, 32'h11112222, 4'hF, -1, -1, rc, rn, rd, er, sc, dirty);
        xfer(3, 1'b0, 32'h10, 32'h0, 4'h0, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("prefill 0x10 ws2: ready_cyc=%0d data=%h", rc, rd);
        total++;
        if (rc !== 4 || rd !== 32'h11112222) begin
            bad++;
            $display("FAIL prefill: got cyc=%0d data=%h want 4/11112222", rc, rd);
        end
        xfer(3, 1'b1, 32'h0C, 32'hAAAA5555, 4'hF, -1, 2, rc, rn, rd, er, sc, dirty);
        $display("write 0x0C with reset ws2: ready_n=%0d dirty=%b", rn, dirty);
        total++;
        if (rn !== 0 || dirty !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: got ready_n=%0d dirty=%b want 0/0", rn, dirty);
        end
        xfer(3, 1'b0, 32'h0C, 32'h0, 4'h0, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("read 0x0C ws2: data=%h", rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL rst_no_write: got %h want 0", rd);
        end
        xfer(3, 1'b0, 32'h10, 32'h0, 4'h0, -1, -1, rc, rn, rd, er, sc, dirty);
        $display("read 0x10 ws2: data=%h", rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL rst_cleared: got %h want 0", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rdy;
        logic [31:0] rd;
        rdy = '0;
        rd  = '0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            case (c)
                0: apbi[0] = '{pselx: 1'b1, penable: 1'b0, pwrite: 1'b1, paddr: 32'h14,
                               pwdata: 32'hCAFEF00D, pstrb: 4'hF, pprot: 3'b000};
                1: apbi[0].penable = 1'b1;
                3: apbi[0] = '{pselx: 1'b1, penable: 1'b0, pwrite: 1'b0, paddr: 32'h14,
                               pwdata: 32'h0, pstrb: 4'h0, pprot: 3'b111};
                4: apbi[0].penable = 1'b1;
                6: apbi[0] = '0;
                default: ;
            endcase
            @(negedge clk);
            if (c >= 2 && c <= 5) rdy[c-2] = apbo[0].pready;
            if (c == 5) rd = apbo[0].prdata;
        end
        $display("back_to_back: ready c2..c5=%b data=%h", rdy, rd);
        total++;
        if (rdy !== 4'b1001) begin
            bad++;
            $display("FAIL b2b_ready: got %b want 1001", rdy);
        end
        total++;
        if (rd !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL b2b_data: got %h want cafef00d", rd);
        end
    endtask

    initial begin
        mapinfo = '{addr_start: 32'h8000_1000, addr_end: 32'h8000_2000};
        test_reset();
        test_write_full();
        test_strobe();
        test_id();
        test_bad_addr();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_regbank_slv.md
APB_REGBANK_SLV -- requirements
Module: apb_regbank_slv

Interface
REQ-001 The block SHALL have parameter waitstates, default 0, giving the extra APB access cycles inserted before pready (range 0..15).
REQ-002 The block SHALL have parameter vid, default VENDOR_OPTIMITY, giving the vendor ID reported in o_cfg.
REQ-003 The block SHALL have parameter did, default OPTIMITY_DID_APB_REGBANK, giving the device ID reported in o_cfg.
REQ-004 Port i_clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-005 Port i_nrst, input, 1, reset; asynchronous, active-low.
REQ-006 Port i_mapinfo, input, mapinfo_type, base and end address from the bus1 PnP map.
REQ-007 Port o_cfg, output, dev_config_type, PnP descriptor (descrsize, desctype=PNP_CFG_TYPE_SLAVE, addr_start/addr_end from i_mapinfo, vid, did).
REQ-008 Port i_apbi, input, apb_in_type, APB requester signals (pselx, penable, pwrite, paddr[31:0], pwdata[31:0], pstrb[3:0], pprot[2:0]).
REQ-009 Port o_apbo, output, apb_out_type, completer response (pready, prdata[31:0], pslverr).
REQ-010 Port o_scratch, output, 32, registered copy of register 1 (SCRATCH).

Function
REQ-011 The block SHALL implement 8 32-bit registers selected by paddr[4:2]: 0 = ID (read-only, value {vid[15:0], did[15:0]}), 1..7 = read/write.
REQ-012 An access SHALL be an error when paddr[11:5] != 0, or when it is a write to register 0.
REQ-013 The FSM SHALL have states Idle, Wait and Resp, held in a 2-bit register.
REQ-014 Idle -> Wait SHALL occur when pselx=1 and penable=0. On that edge the block latches paddr[11:2], pwrite, pwdata and pstrb, and loads wcnt=waitstates.
REQ-015 In Wait with wcnt != 0, wcnt SHALL decrement by 1 per cycle.
REQ-016 In Wait with wcnt == 0, the block SHALL perform the latched access on the next edge and enter Resp.
- A write SHALL update only the bytes whose pstrb bit is 1.
- A read SHALL register the selected word into prdata.
- An error SHALL set pslverr=1, leave all registers unchanged and register prdata=0.
REQ-017 In Resp, pready SHALL be 1 and prdata/pslverr SHALL be valid; the next edge SHALL return the FSM to Idle.
REQ-018 pready SHALL be decoded only from state==Resp. Outside Resp, pready, pslverr and prdata SHALL all be 0.
REQ-019 Latency: counting the setup cycle as cycle 0, pready SHALL be 1 in cycle waitstates+2 and in no other cycle of the transfer.
REQ-020 If pselx=0 while in Wait (requester abort), the FSM SHALL return to Idle on the next edge with no register write and no pready.
REQ-021 A setup phase arriving in Resp SHALL be ignored.
REQ-022 A new setup phase arriving in Idle in the cycle after Resp SHALL be accepted, so back-to-back transfers are supported.
REQ-023 pprot SHALL be ignored.
REQ-024 Bits paddr[1:0] SHALL be ignored.
REQ-025 wcnt SHALL be 4 bits wide and SHALL NOT wrap below 0.

Reset
REQ-026 While i_nrst=0, the state SHALL be Idle, wcnt 0, all latched request fields 0, registers 1..7 0, prdata 0, pslverr 0, pready 0 and o_scratch 0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer immediately; no partial write SHALL remain after reset.
REQ-028 o_cfg SHALL be combinational and valid during reset.

Structure
REQ-029 Package apb_regbank_slv_pkg SHALL hold:
- the state localparams State_Idle/State_Wait/State_Resp;
- register index constants;
- the apb_regbank_slv_registers struct;
- the reset constant apb_regbank_slv_r_reset.
REQ-030 The block SHALL be a single module in the two-process style: combinational next-state and registered update with async reset. No sub-module is required.

Verification
REQ-031 waitstates=0, write addr 0x04, data 0xDEADBEEF, pstrb=0xF -> pready=1 exactly in cycle 2, pslverr=0, o_scratch=0xDEADBEEF one cycle later.
REQ-032 After REQ-031, write addr 0x04, data 0x00000055, pstrb=0x1, then read 0x04 -> prdata=0xDEADBE55, pslverr=0.
REQ-033 waitstates=3, read addr 0x00 -> pready=1 only in cycle 5, prdata={vid,did}; a write to 0x00 -> pslverr=1 and the ID is unchanged.
REQ-034 Read addr 0x40 -> pslverr=1, prdata=0; no register changes.
REQ-035 waitstates=5, write 0x08=0x12345678 with pselx dropped in cycle 2 -> no pready; a subsequent read of 0x08 returns 0.
REQ-036 waitstates=2, write 0x0C=0xAAAA5555 with i_nrst pulsed low in cycle 2 -> all outputs 0 during reset; a subsequent read of 0x0C returns 0.
